// File: rtl/port_io_bus_master_pkg.sv
// port_io_bus_master_pkg: slot states, register offsets and port limit shared by the port-I/O bus master
package port_io_bus_master_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DIR, S_OUT, S_IN} slot_t;
  localparam logic [1:0] REG_DIR = 2'd0;
  localparam logic [1:0] REG_OUT = 2'd1;
  localparam logic [1:0] REG_IN = 2'd2;
  localparam int MAX_PORTS = 10;
endpackage

// File: rtl/port_io_bus_master_regbank.sv
// port_io_regbank: shadow/active DIR-OUT registers, IN staging/published arrays and host readback
module port_io_regbank
  import port_io_bus_master_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_we,
  input  logic [3:0] host_port,
  input  logic [1:0] host_reg,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  input  logic       latch,
  input  logic       sample,
  input  logic       publish,
  input  logic [3:0] slot_port,
  input  logic [7:0] bus_in,
  output logic [7:0] act_dir,
  output logic [7:0] act_out
);
  localparam logic [3:0] LAST = 4'(NUM_PORTS - 1);
  logic [7:0] sh_dir [MAX_PORTS];
  logic [7:0] sh_out [MAX_PORTS];
  logic [7:0] a_dir [MAX_PORTS];
  logic [7:0] a_out [MAX_PORTS];
  logic [7:0] stg [MAX_PORTS];
  logic [7:0] pub [MAX_PORTS];
  assign act_dir = a_dir[slot_port];
  assign act_out = a_out[slot_port];
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_dir <= '{default: '0};
      sh_out <= '{default: '0};
      a_dir <= '{default: '0};
      a_out <= '{default: '0};
      stg <= '{default: '0};
      pub <= '{default: '0};
      host_rdata <= '0;
    end else begin
      // latch copies the pre-write shadow, so a same-cycle host write lands in the next frame
      if (latch) begin
        a_dir <= sh_dir;
        a_out <= sh_out;
      end
      if (host_we && host_port <= LAST && host_reg == REG_DIR) sh_dir[host_port] <= host_wdata;
      if (host_we && host_port <= LAST && host_reg == REG_OUT) sh_out[host_port] <= host_wdata;
      if (sample) stg[slot_port] <= bus_in;
      if (publish) begin
        pub <= stg;
        pub[slot_port] <= bus_in;
      end
      host_rdata <= (host_port > LAST) ? '0 :
                    (host_reg == REG_DIR) ? sh_dir[host_port] :
                    (host_reg == REG_OUT) ? sh_out[host_port] :
                    (host_reg == REG_IN) ? pub[host_port] : '0;
    end
  end
endmodule

// File: rtl/port_io_bus_master.sv
// port_io_bus_master: replays host port registers as a SYNC + {DIR,OUT,IN} x N slot frame on a shared bus
module port_io_bus_master
  import port_io_bus_master_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  inout  wire  [7:0]        data,
  output logic              frame_start,
  output logic              frame_done
);
  localparam logic [3:0] LAST = 4'(NUM_PORTS - 1);
  slot_t state;
  logic [3:0] port;
  logic oe;
  logic [7:0] act_dir, act_out, drive_byte;
  assign drive_byte = (state == S_OUT) ? act_out : act_dir;
  assign data = oe ? drive_byte : 8'hzz;
  // outputs are registered from the next state so they line up with the slot they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      port <= '0;
      oe <= 1'b0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      oe <= 1'b0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          state <= S_SYNC;
          frame_start <= 1'b1;
        end
        S_SYNC: begin
          state <= S_DIR;
          port <= '0;
          oe <= 1'b1;
        end
        S_DIR: begin
          state <= S_OUT;
          oe <= 1'b1;
        end
        S_OUT: state <= S_IN;
        S_IN: if (port == LAST) begin
          frame_done <= 1'b1;
          state <= enable ? S_SYNC : S_IDLE;
          frame_start <= enable;
        end else begin
          port <= port + 4'd1;
          state <= S_DIR;
          oe <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  port_io_regbank #(.NUM_PORTS(NUM_PORTS)) u_regbank (
    .clk(clk),
    .rst(rst),
    .host_we(host_we),
    .host_port(host_addr[5:2]),
    .host_reg(host_addr[1:0]),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .latch(state == S_SYNC),
    .sample(state == S_IN),
    .publish(state == S_IN && port == LAST),
    .slot_port(port),
    .bus_in(data),
    .act_dir(act_dir),
    .act_out(act_out)
  );
endmodule

// File: tb/tb_port_io_bus_master.sv
// tb_port_io_bus_master: frame-position reference model checked cycle by cycle against the bus master
module tb_port_io_bus_master;
  localparam int N = 3;
  logic clk = 0, rst = 1, enable = 0, host_we = 0;
  logic [5:0] host_addr = '0;
  logic [7:0] host_wdata = '0, host_rdata, drv = '0;
  logic drv_en = 0, frame_start, frame_done, use_3c = 0;
  wire [7:0] data;
  int tests = 0, fails = 0, pos = -1;
  logic [7:0] sh_dir [N], sh_out [N], a_dir [N], a_out [N], stg [N], pub [N];
  assign data = drv_en ? drv : 8'hzz;
  always #5 clk = ~clk;
  port_io_bus_master #(.NUM_PORTS(N), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .enable(enable), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .data(data),
    .frame_start(frame_start), .frame_done(frame_done)
  );
  // pos = position of the current cycle inside a frame (0 = SYNC, 1+3p+j = slot j of port p), -1 = idle
  task automatic tick();
    int nxt, p, r;
    logic fd_e;
    logic [7:0] rd_e, d_e;
    drv_en = (pos > 0 && pos % 3 == 0);
    drv = (use_3c && pos == 6) ? 8'h3C : 8'($urandom);
    p = int'(host_addr[5:2]);
    r = int'(host_addr[1:0]);
    rd_e = (p >= N) ? 8'h00 : (r == 0) ? sh_dir[p] : (r == 1) ? sh_out[p] : (r == 2) ? pub[p] : 8'h00;
    fd_e = 0;
    if (pos == -1) nxt = enable ? 0 : -1;
    else if (pos == 0) begin
      a_dir = sh_dir;
      a_out = sh_out;
      nxt = 1;
    end else if (pos % 3 == 0) begin
      stg[pos / 3 - 1] = drv;
      if (pos == 3 * N) begin
        pub = stg;
        fd_e = 1;
        nxt = enable ? 0 : -1;
      end else nxt = pos + 1;
    end else nxt = pos + 1;
    if (host_we && p < N && r == 0) sh_dir[p] = host_wdata;
    if (host_we && p < N && r == 1) sh_out[p] = host_wdata;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        sh_dir[i] = 0; sh_out[i] = 0; a_dir[i] = 0; a_out[i] = 0; stg[i] = 0; pub[i] = 0;
      end
      rd_e = 0;
      fd_e = 0;
      nxt = -1;
    end
    @(posedge clk);
    #1 drv_en = 0;
    #1;
    pos = nxt;
    d_e = (pos > 0 && pos % 3 == 1) ? a_dir[(pos - 1) / 3] :
          (pos > 0 && pos % 3 == 2) ? a_out[(pos - 1) / 3] : 8'hzz;
    tests++;
    assert (frame_start === (pos == 0)) else begin
      fails++;
      $error("FAIL frame_start pos=%0d got %b exp %b", pos, frame_start, pos == 0);
    end
    tests++;
    assert (frame_done === fd_e) else begin
      fails++;
      $error("FAIL frame_done pos=%0d got %b exp %b", pos, frame_done, fd_e);
    end
    tests++;
    assert (host_rdata === rd_e) else begin
      fails++;
      $error("FAIL host_rdata addr=%h got %h exp %h", host_addr, host_rdata, rd_e);
    end
    tests++;
    assert (data === d_e) else begin
      fails++;
      $error("FAIL data pos=%0d got %h exp %h", pos, data, d_e);
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    host_we = 1;
    host_addr = a;
    host_wdata = d;
    tick();
    host_we = 0;
  endtask
  task automatic wait_pos(input int target);
    for (int i = 0; i < 40 && pos != target; i++) tick();
    tests++;
    assert (pos == target) else begin
      fails++;
      $error("FAIL wait_pos got %0d exp %0d", pos, target);
    end
  endtask
  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      host_addr = 6'(a);
      tick();
    end
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    repeat (5) tick();
    read_all();
    wr({4'd0, 2'd0}, 8'hFF);
    wr({4'd0, 2'd1}, 8'h5A);
    enable = 1;
    repeat (25) tick();
    use_3c = 1;
    host_addr = {4'd1, 2'd2};
    wait_pos(6);
    repeat (8) tick();
    use_3c = 0;
    wait_pos(0);
    wr({4'd2, 2'd1}, 8'h11);
    repeat (22) tick();
    for (int i = 0; i < 300; i++) begin
      host_we = ($urandom_range(0, 3) == 0);
      host_addr = 6'($urandom);
      host_wdata = 8'($urandom);
      if ($urandom_range(0, 30) == 0) enable = ~enable;
      tick();
    end
    host_we = 0;
    enable = 1;
    wait_pos(4);
    enable = 0;
    repeat (15) tick();
    enable = 1;
    wait_pos(5);
    rst = 1;
    tick();
    rst = 0;
    enable = 0;
    read_all();
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
